cvxif_copro_responder: RTL and testbench

- Coprocessor-side endpoint of the CV-X-IF link; it is the responder to the core's CV-X-IF issue/commit/result traffic.
- Decodes issued custom-0 instructions and returns accept or reject in the issue handshake.
- Holds an accepted instruction until the core commits or kills it, then executes it and returns the result through a small result FIFO.
- Serves as the reference coprocessor for core-level CV-X-IF verification.

---
 rtl/cvxif_copro_responder_if.sv | 41 ++++
 rtl/cvxif_copro_responder.sv | 166 ++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_copro_responder_if.sv
// CV-X-IF issue/commit/result bundle between a core (master) and the
// reference coprocessor (slave). Signal suffixes are from the coprocessor's view.
interface cvxif_copro_responder_if #(
  parameter int XLEN    = 64,
  parameter int IdWidth = 4
);
  logic               issue_valid_i;
  logic               issue_ready_o;
  logic [31:0]        issue_instr_i;
  logic [IdWidth-1:0] issue_id_i;
  logic [XLEN-1:0]    issue_rs1_i;
  logic [XLEN-1:0]    issue_rs2_i;
  logic [1:0]         issue_rs_valid_i;
  logic               issue_accept_o;
  logic               issue_writeback_o;

  logic               commit_valid_i;
  logic [IdWidth-1:0] commit_id_i;
  logic               commit_kill_i;

  logic               result_valid_o;
  logic               result_ready_i;
  logic [IdWidth-1:0] result_id_o;
  logic [XLEN-1:0]    result_data_o;
  logic [4:0]         result_rd_o;
  logic               result_we_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
           issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
           result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
           issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
           result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/cvxif_copro_responder.sv
// Reference CV-X-IF coprocessor: decodes custom-0 ADD/XOR/SLL/MUL, waits for
// commit, executes (MUL by iterative shift-add) and queues results in a FWFT FIFO.
module cvxif_copro_responder #(
  parameter int XLEN        = 64,
  parameter int IdWidth     = 4,
  parameter int ResultDepth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  cvxif_copro_responder_if.slave bus
);

  localparam int ShW  = $clog2(XLEN);
  localparam int PtrW = $clog2(ResultDepth);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, DONE} state_e;

  state_e             state_q, state_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [1:0]         op_q, op_d;
  logic [4:0]         rd_q, rd_d;
  logic [XLEN-1:0]    rs1_q, rs1_d;
  logic [XLEN-1:0]    rs2_q, rs2_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [ShW-1:0]     cnt_q, cnt_d;

  logic [IdWidth-1:0] fifoId_q   [ResultDepth];
  logic [XLEN-1:0]    fifoData_q [ResultDepth];
  logic [4:0]         fifoRd_q   [ResultDepth];
  logic               fifoWe_q   [ResultDepth];
  logic [PtrW-1:0]    wptr_q, rptr_q;
  logic [PtrW:0]      count_q;

  logic legal, issueReady, handshake, commitHit, resultValid;
  logic fifoFull, push, pop;
  logic [XLEN-1:0] aluResult;
  logic unused_instrBits;

  assign unused_instrBits = ^bus.issue_instr_i[24:15];

  // Legal iff custom-0 opcode, funct7 == 0 and funct3 in 0..3 (bit 14 clear).
  assign legal = (bus.issue_instr_i[6:0] == 7'b0001011) &&
                 (bus.issue_instr_i[31:25] == 7'd0) && !bus.issue_instr_i[14];

  assign issueReady = !rst_i && (state_q == IDLE) && (&bus.issue_rs_valid_i);
  assign handshake  = bus.issue_valid_i && issueReady;
  assign commitHit  = bus.commit_valid_i && (bus.commit_id_i == id_q);

  assign bus.issue_ready_o     = issueReady;
  assign bus.issue_accept_o    = handshake && legal;
  assign bus.issue_writeback_o = handshake && legal && (bus.issue_instr_i[11:7] != 5'd0);

  assign fifoFull    = (count_q == (PtrW+1)'(ResultDepth));
  assign resultValid = !rst_i && (count_q != '0);
  assign pop         = resultValid && bus.result_ready_i;

  assign bus.result_valid_o = resultValid;
  assign bus.result_id_o    = fifoId_q[rptr_q];
  assign bus.result_data_o  = fifoData_q[rptr_q];
  assign bus.result_rd_o    = fifoRd_q[rptr_q];
  assign bus.result_we_o    = fifoWe_q[rptr_q];

  always_comb begin
    aluResult = '0;
    unique case (op_q)
      2'd0:    aluResult = rs1_q + rs2_q;
      2'd1:    aluResult = rs1_q ^ rs2_q;
      2'd2:    aluResult = rs1_q << rs2_q[ShW-1:0];
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (handshake && legal) begin
          id_d    = bus.issue_id_i;
          op_d    = bus.issue_instr_i[13:12];
          rd_d    = bus.issue_instr_i[11:7];
          rs1_d   = bus.issue_rs1_i;
          rs2_d   = bus.issue_rs2_i;
          state_d = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (commitHit) begin
          if (bus.commit_kill_i) begin
            state_d = IDLE;
          end else if (op_q == 2'd3) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = EXEC;
          end else begin
            acc_d   = aluResult;
            state_d = DONE;
          end
        end
      end
      // One multiplier bit per cycle, LSB first; the last add lands with the DONE transition.
      EXEC: begin
        if (rs2_q[cnt_q]) acc_d = acc_q + (rs1_q << cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ShW'(XLEN-1)) state_d = DONE;
      end
      DONE: begin
        if (!fifoFull || pop) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoId_q[wptr_q]   <= id_q;
      fifoData_q[wptr_q] <= acc_q;
      fifoRd_q[wptr_q]   <= rd_q;
      fifoWe_q[wptr_q]   <= (rd_q != 5'd0);
    end
  end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_cvxif_copro_responder;

  localparam int XLEN        = 64;
  localparam int IdWidth     = 4;
  localparam int ResultDepth = 2;
  localparam int Budget      = XLEN + 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cvxif_copro_responder_if #(.XLEN(XLEN), .IdWidth(IdWidth)) bus ();

  cvxif_copro_responder #(.XLEN(XLEN), .IdWidth(IdWidth), .ResultDepth(ResultDepth)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  id;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        expAcc;
    logic        expWb;
    logic [63:0] expData;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  res_t expQ[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic refLegal(input logic [31:0] i);
    return (i[6:0] == 7'h0B) && (i[31:25] == 7'd0) && (i[14:12] <= 3'd3);
  endfunction

  function automatic logic [63:0] refCompute(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [63:0] r;
    case (f3)
      3'd0:    r = a + b;
      3'd1:    r = a ^ b;
      3'd2:    r = a << b[5:0];
      default: r = a * b;
    endcase
    return r;
  endfunction

  // All tasks start and end at a falling edge, so the DUT samples stable inputs.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] id,
                               input logic [63:0] a, input logic [63:0] b,
                               output logic acc, output logic wb, output logic rdy);
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = instr;
    bus.issue_id_i    = id;
    bus.issue_rs1_i   = a;
    bus.issue_rs2_i   = b;
    #1;
    rdy = bus.issue_ready_o;
    acc = bus.issue_accept_o;
    wb  = bus.issue_writeback_o;
    @(negedge clk);
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic doCommit(input logic [3:0] id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
    @(negedge clk);
    bus.commit_valid_i = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!bus.result_valid_o && lat < Budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (!bus.issue_ready_o && n < Budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".back_to_idle"}, bus.issue_ready_o, 1'b1);
  endtask

  task automatic popCheck(input res_t e, input string tag);
    checkOutput({tag, ".valid"}, bus.result_valid_o, 1'b1);
    checkOutput({tag, ".id"},    bus.result_id_o,    e.id);
    checkOutput({tag, ".data"},  bus.result_data_o,  e.data);
    checkOutput({tag, ".rd"},    bus.result_rd_o,    e.rd);
    checkOutput({tag, ".we"},    bus.result_we_o,    e.we);
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic acc, wb, rdy;
    int   lat;
    res_t e;

    vecs[0] = '{"add",      mkInstr(7'd0, 3'd0, 5'd5,  7'h0B), 4'd3,  64'd10, 64'd7, 1'b1, 1'b1, 64'd17};
    vecs[1] = '{"illop",    mkInstr(7'd0, 3'd0, 5'd5,  7'h33), 4'd4,  64'd1,  64'd2, 1'b0, 1'b0, 64'd0};
    vecs[2] = '{"mul_neg",  mkInstr(7'd0, 3'd3, 5'd7,  7'h0B), 4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3] = '{"xor",      mkInstr(7'd0, 3'd1, 5'd31, 7'h0B), 4'd1,  64'hF0F0, 64'hFF00, 1'b1, 1'b1, 64'h0FF0};
    vecs[4] = '{"sll_mask", mkInstr(7'd0, 3'd2, 5'd1,  7'h0B), 4'd15, 64'd1,  64'h43, 1'b1, 1'b1, 64'd8};
    vecs[5] = '{"add_rd0",  mkInstr(7'd0, 3'd0, 5'd0,  7'h0B), 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'd0};
    vecs[6] = '{"illf7",    mkInstr(7'd1, 3'd0, 5'd2,  7'h0B), 4'd2,  64'd1,  64'd1, 1'b0, 1'b0, 64'd0};
    vecs[7] = '{"illf3",    mkInstr(7'd0, 3'd4, 5'd2,  7'h0B), 4'd2,  64'd1,  64'd1, 1'b0, 1'b0, 64'd0};
    vecs[8] = '{"mul_wrap", mkInstr(7'd0, 3'd3, 5'd9,  7'h0B), 4'd8,  64'h8000_0000_0000_0001, 64'd2, 1'b1, 1'b1, 64'd2};
    vecs[9] = '{"sll_63",   mkInstr(7'd0, 3'd2, 5'd30, 7'h0B), 4'd12, 64'd3,  64'd63, 1'b1, 1'b1, 64'h8000_0000_0000_0000};

    bus.issue_valid_i    = 1'b1;
    bus.issue_instr_i    = mkInstr(7'd0, 3'd0, 5'd5, 7'h0B);
    bus.issue_id_i       = '0;
    bus.issue_rs1_i      = '0;
    bus.issue_rs2_i      = '0;
    bus.issue_rs_valid_i = 2'b11;
    bus.commit_valid_i   = 1'b0;
    bus.commit_id_i      = '0;
    bus.commit_kill_i    = 1'b0;
    bus.result_ready_i   = 1'b0;

    #2;
    checkOutput("rst.issue_ready",  bus.issue_ready_o,     1'b0);
    checkOutput("rst.accept",       bus.issue_accept_o,    1'b0);
    checkOutput("rst.writeback",    bus.issue_writeback_o, 1'b0);
    checkOutput("rst.result_valid", bus.result_valid_o,    1'b0);
    repeat (2) @(negedge clk);
    bus.issue_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("post_rst.issue_ready", bus.issue_ready_o, 1'b1);
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].instr, vecs[v].id, vecs[v].rs1, vecs[v].rs2, acc, wb, rdy);
      checkOutput({vecs[v].name, ".ready"},     rdy, 1'b1);
      checkOutput({vecs[v].name, ".accept"},    acc, vecs[v].expAcc);
      checkOutput({vecs[v].name, ".writeback"}, wb,  vecs[v].expWb);
      if (vecs[v].expAcc) begin
        doCommit(vecs[v].id, 1'b0);
        waitResult(lat);
        checkOutput({vecs[v].name, ".latency"}, 64'(lat),
                    (vecs[v].instr[14:12] == 3'd3) ? 64'(XLEN + 2) : 64'd2);
        e = '{vecs[v].id, vecs[v].expData, vecs[v].instr[11:7], vecs[v].instr[11:7] != 5'd0};
        popCheck(e, vecs[v].name);
        waitIdle(vecs[v].name);
      end else begin
        checkOutput({vecs[v].name, ".ready_next"}, bus.issue_ready_o, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput({vecs[v].name, ".no_result"}, bus.result_valid_o, 1'b0);
      end
    end

    // Operand-valid gating: a missing operand blocks the handshake entirely.
    bus.issue_rs_valid_i = 2'b01;
    applyStimulus(mkInstr(7'd0, 3'd0, 5'd1, 7'h0B), 4'd1, 64'd1, 64'd1, acc, wb, rdy);
    checkOutput("rs2_missing.ready",  rdy, 1'b0);
    checkOutput("rs2_missing.accept", acc, 1'b0);
    bus.issue_rs_valid_i = 2'b10;
    applyStimulus(mkInstr(7'd0, 3'd0, 5'd1, 7'h0B), 4'd1, 64'd1, 64'd1, acc, wb, rdy);
    checkOutput("rs1_missing.ready",  rdy, 1'b0);
    bus.issue_rs_valid_i = 2'b11;

    doCommit(4'd1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("idle_commit.no_result", bus.result_valid_o, 1'b0);

    applyStimulus(mkInstr(7'd0, 3'd1, 5'd3, 7'h0B), 4'd6, 64'd5, 64'd6, acc, wb, rdy);
    checkOutput("kill.accept", acc, 1'b1);
    doCommit(4'd7, 1'b0);
    checkOutput("kill.wrong_id_ignored", bus.issue_ready_o, 1'b0);
    doCommit(4'd6, 1'b1);
    checkOutput("kill.back_to_idle", bus.issue_ready_o, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("kill.no_result", bus.result_valid_o, 1'b0);
    applyStimulus(mkInstr(7'd0, 3'd0, 5'd4, 7'h0B), 4'd2, 64'd100, 64'd23, acc, wb, rdy);
    checkOutput("kill.next_accept", acc, 1'b1);
    doCommit(4'd2, 1'b0);
    waitResult(lat);
    popCheck('{4'd2, 64'd123, 5'd4, 1'b1}, "kill.next");
    waitIdle("kill.next");

    // Three results against a two-deep FIFO with the consumer stalled.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mkInstr(7'd0, 3'd0, 5'(k + 1), 7'h0B), 4'(10 + k), 64'(k), 64'd1000, acc, wb, rdy);
      checkOutput("full.accept", acc, 1'b1);
      doCommit(4'(10 + k), 1'b0);
      if (k < 2) waitIdle("full.queue");
    end
    repeat (4) @(negedge clk);
    checkOutput("full.done_holds", bus.issue_ready_o, 1'b0);
    popCheck('{4'd10, 64'd1000, 5'd1, 1'b1}, "full.r0");
    checkOutput("full.push_released", bus.issue_ready_o, 1'b1);
    popCheck('{4'd11, 64'd1001, 5'd2, 1'b1}, "full.r1");
    popCheck('{4'd12, 64'd1002, 5'd3, 1'b1}, "full.r2");
    checkOutput("full.drained", bus.result_valid_o, 1'b0);

    applyStimulus(mkInstr(7'd0, 3'd0, 5'd1, 7'h0B), 4'd4, 64'd1, 64'd1, acc, wb, rdy);
    doCommit(4'd4, 1'b0);
    waitIdle("rst_mid.queued");
    applyStimulus(mkInstr(7'd0, 3'd3, 5'd2, 7'h0B), 4'd5, 64'd7, 64'd9, acc, wb, rdy);
    doCommit(4'd5, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("rst_mid.pre_valid", bus.result_valid_o, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid.valid",       bus.result_valid_o, 1'b0);
    checkOutput("rst_mid.issue_ready", bus.issue_ready_o,  1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid.idle_after",  bus.issue_ready_o,  1'b1);
    checkOutput("rst_mid.fifo_empty",  bus.result_valid_o, 1'b0);
    repeat (XLEN + 5) @(negedge clk);
    checkOutput("rst_mid.mul_discarded", bus.result_valid_o, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [6:0]  f7, opc;
      logic [4:0]  rd;
      logic [3:0]  id;
      logic [63:0] a, b;
      logic [31:0] instr;
      logic        lg, kill;
      int          kind;
      if (expQ.size() == ResultDepth || (expQ.size() > 0 && $urandom_range(1, 0) == 1)) begin
        e = expQ.pop_front();
        popCheck(e, "rand.pop");
      end
      if (expQ.size() == 0) checkOutput("rand.empty", bus.result_valid_o, 1'b0);
      kind = $urandom_range(9, 0);
      f3   = 3'($urandom_range(3, 0));
      f7   = 7'd0;
      opc  = 7'h0B;
      if (kind == 0) opc = 7'h33;
      if (kind == 1) f7 = 7'($urandom_range(127, 1));
      if (kind == 2) f3 = 3'($urandom_range(7, 4));
      rd    = 5'($urandom_range(31, 0));
      id    = 4'($urandom_range(15, 0));
      a     = {$urandom, $urandom};
      b     = ($urandom_range(1, 0) == 1) ? {$urandom, $urandom} : 64'($urandom_range(70, 0));
      instr = mkInstr(f7, f3, rd, opc);
      lg    = refLegal(instr);
      applyStimulus(instr, id, a, b, acc, wb, rdy);
      checkOutput("rand.ready",     rdy, 1'b1);
      checkOutput("rand.accept",    acc, lg);
      checkOutput("rand.writeback", wb,  lg && (rd != 5'd0));
      if (lg) begin
        if ($urandom_range(3, 0) == 0) doCommit(id + 4'd1, 1'b0);
        kill = ($urandom_range(3, 0) == 0);
        doCommit(id, kill);
        if (!kill) expQ.push_back('{id, refCompute(f3, a, b), rd, rd != 5'd0});
        waitIdle("rand");
      end
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      popCheck(e, "rand.drain");
    end
    checkOutput("rand.final_empty", bus.result_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
